// File: rtl/dmem_bridge_if.sv
// ---------------------------------------------------------------------------
// dmem_bridge_if
// Bundles the three channels around the data-memory bridge:
//   req_*   LSU -> bridge request channel (valid/ready), bridge drives req_ready
//   resp_*  bridge -> LSU response channel (valid/ready), LSU drives resp_ready
//   dmem_*  bridge -> RAM data port, RAM returns dmem_rdata combinationally
// Modports:
//   slave   the bridge itself
//   master  the LSU plus RAM side (the environment around the bridge)
// ---------------------------------------------------------------------------
interface dmem_bridge_if;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [1:0]  req_size;
   logic        req_wen;
   logic [3:0]  req_id;

   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic [3:0]  resp_id;
   logic        resp_err;

   logic        dmem_en;
   logic [63:0] dmem_addr;
   logic [63:0] dmem_rdata;
   logic [63:0] dmem_wdata;
   logic [63:0] dmem_wmask;
   logic        dmem_wen;

   modport slave (
      input  req_valid, req_addr, req_wdata, req_size, req_wen, req_id,
      input  resp_ready, dmem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_id, resp_err,
      output dmem_en, dmem_addr, dmem_wdata, dmem_wmask, dmem_wen
   );

   modport master (
      output req_valid, req_addr, req_wdata, req_size, req_wen, req_id,
      output resp_ready, dmem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_id, resp_err,
      input  dmem_en, dmem_addr, dmem_wdata, dmem_wmask, dmem_wen
   );
endinterface

// File: rtl/dmem_bridge.sv
// ---------------------------------------------------------------------------
// dmem_bridge
// Accepts one LSU load/store at a time, drives a single RAM access cycle with
// an 8-byte-aligned address, bit-level write mask and lane-shifted store data,
// then returns lane-extracted, zero-extended load data with the request tag
// and an error flag (misaligned or outside the RAM window).
// Ports:
//   clk    single clock, all state changes on posedge
//   reset  synchronous, active-high
//   bus    dmem_bridge_if.slave: req_*, resp_*, dmem_* channels
// Parameters:
//   ADDR_BASE  first legal physical address (matches RAM base)
//   ADDR_SIZE  legal window size in bytes
// Sequence: IDLE --fire--> ACCESS --> RESP --resp_ready--> IDLE or ACCESS.
// ---------------------------------------------------------------------------
module dmem_bridge #(
   parameter logic [63:0] ADDR_BASE = 64'h0000_0000_8000_0000,
   parameter logic [63:0] ADDR_SIZE = 64'h0000_0000_0800_0000
) (
   input  logic clk,
   input  logic reset,
   dmem_bridge_if.slave bus
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   localparam logic [63:0] WINDOW_END = ADDR_BASE + ADDR_SIZE;

   logic [1:0]  state;

   logic [63:0] addr_q;
   logic [63:0] wdata_q;
   logic [1:0]  size_q;
   logic        wen_q;
   logic [3:0]  id_q;
   logic        err_q;

   logic [63:0] resp_rdata_q;
   logic [3:0]  resp_id_q;
   logic        resp_err_q;

   logic        fire;
   logic        misaligned;
   logic        out_of_window;
   logic        req_err;
   logic        in_access;
   logic [5:0]  shamt;
   logic [63:0] lane_mask;
   logic [63:0] rdata_lane;

   // A new request can be taken when idle, or when the pending response is
   // being consumed this very cycle, which gives back-to-back RESP->ACCESS.
   assign bus.req_ready = !reset &&
                          ((state == IDLE) || ((state == RESP) && bus.resp_ready));
   assign fire = bus.req_valid && bus.req_ready;

   // Alignment check: the low log2(size) address bits must be zero.
   always_comb begin
      misaligned = 1'b0;
      case (bus.req_size)
         2'd0:    misaligned = 1'b0;
         2'd1:    misaligned = bus.req_addr[0];
         2'd2:    misaligned = |bus.req_addr[1:0];
         default: misaligned = |bus.req_addr[2:0];
      endcase
   end

   assign out_of_window = (bus.req_addr < ADDR_BASE) || (bus.req_addr >= WINDOW_END);
   assign req_err       = misaligned || out_of_window;

   // Byte-lane mask of the access width, right-justified; shifted into place
   // for stores and used directly to trim extracted load data.
   always_comb begin
      lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
      case (size_q)
         2'd0:    lane_mask = 64'h0000_0000_0000_00FF;
         2'd1:    lane_mask = 64'h0000_0000_0000_FFFF;
         2'd2:    lane_mask = 64'h0000_0000_FFFF_FFFF;
         default: lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
   end

   // RAM port is only live in ACCESS and is fully quiet while reset is high,
   // so a reset landing on the access cycle cannot commit a write.
   assign in_access  = (state == ACCESS) && !reset;
   assign shamt      = {addr_q[2:0], 3'b000};
   assign rdata_lane = (bus.dmem_rdata >> shamt) & lane_mask;

   assign bus.dmem_en    = in_access && !err_q;
   assign bus.dmem_wen   = in_access && !err_q && wen_q;
   assign bus.dmem_addr  = in_access ? {addr_q[63:3], 3'b000} : 64'd0;
   assign bus.dmem_wmask = (in_access && wen_q) ? (lane_mask << shamt) : 64'd0;
   assign bus.dmem_wdata = in_access ? (wdata_q << shamt) : 64'd0;

   assign bus.resp_valid = (state == RESP);
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_id    = resp_id_q;
   assign bus.resp_err   = resp_err_q;

   // Main sequencer. Reset always returns to IDLE, which drops any request
   // in flight and any response not yet consumed.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    state <= fire ? ACCESS : IDLE;
            ACCESS:  state <= RESP;
            RESP:    if (bus.resp_ready) state <= fire ? ACCESS : IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Request holding registers, loaded on every accepted request together
   // with the error verdict so ACCESS needs no further decoding of the window.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q  <= 64'd0;
         wdata_q <= 64'd0;
         size_q  <= 2'd0;
         wen_q   <= 1'b0;
         id_q    <= 4'd0;
         err_q   <= 1'b0;
      end else if (fire) begin
         addr_q  <= bus.req_addr;
         wdata_q <= bus.req_wdata;
         size_q  <= bus.req_size;
         wen_q   <= bus.req_wen;
         id_q    <= bus.req_id;
         err_q   <= req_err;
      end
   end

   // Response registers are written only at the end of ACCESS, so they stay
   // stable through any number of RESP stall cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         resp_rdata_q <= 64'd0;
         resp_id_q    <= 4'd0;
         resp_err_q   <= 1'b0;
      end else if (state == ACCESS) begin
         resp_rdata_q <= (!err_q && !wen_q) ? rdata_lane : 64'd0;
         resp_id_q    <= id_q;
         resp_err_q   <= err_q;
      end
   end

endmodule

// File: tb/tb_dmem_bridge.sv
// ---------------------------------------------------------------------------
// tb_dmem_bridge
// Directed bench for dmem_bridge with a small behavioural RAM (16 doublewords,
// indexed by address bits [6:3]) attached to the dmem_* port.
// ---------------------------------------------------------------------------
module tb_dmem_bridge;

   logic clk = 1'b0;
   logic reset;
   logic memClear;

   int assertCount = 0;
   int failCount   = 0;
   int writeCount  = 0;
   int wcBefore;

   logic [63:0] mem [0:15];

   logic        accEn;
   logic        accWen;
   logic [63:0] accAddr;
   logic [63:0] accWmask;
   logic [63:0] accWdata;
   logic        accRespValid;
   logic        respValid;
   logic [63:0] respRdata;
   logic [3:0]  respId;
   logic        respErr;

   dmem_bridge_if bus ();

   dmem_bridge dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Behavioural RAM: combinational read, masked write at posedge. The clear
   // path loads a recognisable pattern so untouched locations are predictable.
   assign bus.dmem_rdata = mem[bus.dmem_addr[6:3]];

   always @(posedge clk) begin
      if (memClear) begin
         for (int i = 0; i < 16; i++) mem[i] <= 64'hA5A5_5A5A_0000_0000 + 64'(i);
      end else if (bus.dmem_en && bus.dmem_wen) begin
         mem[bus.dmem_addr[6:3]] <= (mem[bus.dmem_addr[6:3]] & ~bus.dmem_wmask) |
                                    (bus.dmem_wdata & bus.dmem_wmask);
         writeCount <= writeCount + 1;
      end
   end

   // Watchdog so a wedged handshake still ends the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      assertCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
      end
   endtask

   // Presents one request, waits for it to fire, samples the RAM port during
   // ACCESS and the response one cycle later (resp_ready is left at 1).
   task automatic applyStimulus(input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [1:0] size, input logic wen, input logic [3:0] id);
      int waitCycles;
      @(negedge clk);
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_size  = size;
      bus.req_wen   = wen;
      bus.req_id    = id;
      bus.req_valid = 1'b1;
      waitCycles = 0;
      while (!bus.req_ready && waitCycles < 20) begin
         @(negedge clk);
         waitCycles++;
      end
      checkOutput("req_ready_before_fire", 64'(bus.req_ready), 64'd1);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      accEn        = bus.dmem_en;
      accWen       = bus.dmem_wen;
      accAddr      = bus.dmem_addr;
      accWmask     = bus.dmem_wmask;
      accWdata     = bus.dmem_wdata;
      accRespValid = bus.resp_valid;
      @(posedge clk);
      @(negedge clk);
      respValid = bus.resp_valid;
      respRdata = bus.resp_rdata;
      respId    = bus.resp_id;
      respErr   = bus.resp_err;
   endtask

   initial begin
      reset         = 1'b1;
      memClear      = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_addr  = 64'd0;
      bus.req_wdata = 64'd0;
      bus.req_size  = 2'd0;
      bus.req_wen   = 1'b0;
      bus.req_id    = 4'd0;
      bus.resp_ready = 1'b1;

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_req_ready",  64'(bus.req_ready),  64'd0);
      checkOutput("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      checkOutput("rst_resp_rdata", bus.resp_rdata,      64'd0);
      checkOutput("rst_resp_id",    64'(bus.resp_id),    64'd0);
      checkOutput("rst_resp_err",   64'(bus.resp_err),   64'd0);
      checkOutput("rst_dmem_en",    64'(bus.dmem_en),    64'd0);
      checkOutput("rst_dmem_wmask", bus.dmem_wmask,      64'd0);
      checkOutput("rst_dmem_addr",  bus.dmem_addr,       64'd0);
      memClear = 1'b0;
      reset    = 1'b0;
      #1 checkOutput("idle_req_ready", 64'(bus.req_ready), 64'd1);
      $display("[TB] reset checks done");

      // Aligned double store, then load back.
      applyStimulus(64'h8000_0010, 64'h1122_3344_5566_7788, 2'd3, 1'b1, 4'd5);
      checkOutput("st8_wmask",      accWmask, 64'hFFFF_FFFF_FFFF_FFFF);
      checkOutput("st8_addr",       accAddr,  64'h8000_0010);
      checkOutput("st8_wdata",      accWdata, 64'h1122_3344_5566_7788);
      checkOutput("st8_en",         64'(accEn),  64'd1);
      checkOutput("st8_wen",        64'(accWen), 64'd1);
      checkOutput("st8_acc_rvalid", 64'(accRespValid), 64'd0);
      checkOutput("st8_rvalid",     64'(respValid), 64'd1);
      checkOutput("st8_rdata",      respRdata, 64'd0);
      checkOutput("st8_id",         64'(respId), 64'd5);
      checkOutput("st8_err",        64'(respErr), 64'd0);

      applyStimulus(64'h8000_0010, 64'd0, 2'd3, 1'b0, 4'd5);
      checkOutput("ld8_wmask",  accWmask, 64'd0);
      checkOutput("ld8_wen",    64'(accWen), 64'd0);
      checkOutput("ld8_rvalid", 64'(respValid), 64'd1);
      checkOutput("ld8_rdata",  respRdata, 64'h1122_3344_5566_7788);
      checkOutput("ld8_id",     64'(respId), 64'd5);
      checkOutput("ld8_err",    64'(respErr), 64'd0);

      // Byte store into lane 3.
      applyStimulus(64'h8000_0013, 64'h0000_0000_0000_00AB, 2'd0, 1'b1, 4'd2);
      checkOutput("stb_wmask", accWmask, 64'h0000_0000_FF00_0000);
      checkOutput("stb_wdata", accWdata, 64'h0000_0000_AB00_0000);
      checkOutput("stb_addr",  accAddr,  64'h8000_0010);

      applyStimulus(64'h8000_0010, 64'd0, 2'd3, 1'b0, 4'd6);
      checkOutput("ld8_after_stb", respRdata, 64'h1122_3344_AB66_7788);
      checkOutput("ld8_after_stb_id", 64'(respId), 64'd6);

      // Half and word extraction from upper lanes.
      applyStimulus(64'h8000_0016, 64'd0, 2'd1, 1'b0, 4'd3);
      checkOutput("ldh_rdata", respRdata, 64'h0000_0000_0000_1122);
      checkOutput("ldh_addr",  accAddr,   64'h8000_0010);

      applyStimulus(64'h8000_0014, 64'd0, 2'd2, 1'b0, 4'd4);
      checkOutput("ldw_rdata", respRdata, 64'h0000_0000_1122_3344);

      // Error cases: misaligned, below window, at window end, last legal.
      wcBefore = writeCount;
      applyStimulus(64'h8000_0002, 64'd0, 2'd2, 1'b0, 4'd7);
      checkOutput("misal_err",   64'(respErr), 64'd1);
      checkOutput("misal_rdata", respRdata, 64'd0);
      checkOutput("misal_en",    64'(accEn), 64'd0);
      checkOutput("misal_id",    64'(respId), 64'd7);

      applyStimulus(64'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3, 1'b1, 4'd8);
      checkOutput("below_err",    64'(respErr), 64'd1);
      checkOutput("below_en",     64'(accEn), 64'd0);
      checkOutput("below_wen",    64'(accWen), 64'd0);
      checkOutput("below_rvalid", 64'(respValid), 64'd1);
      checkOutput("below_writes", 64'(writeCount - wcBefore), 64'd0);

      applyStimulus(64'h8800_0000, 64'd0, 2'd3, 1'b0, 4'd9);
      checkOutput("end_err",   64'(respErr), 64'd1);
      checkOutput("end_rdata", respRdata, 64'd0);

      applyStimulus(64'h87FF_FFF8, 64'd0, 2'd3, 1'b0, 4'd15);
      checkOutput("last_err",   64'(respErr), 64'd0);
      checkOutput("last_rdata", respRdata, 64'hA5A5_5A5A_0000_000F);
      checkOutput("last_id",    64'(respId), 64'd15);

      // Backpressure with a queued request, then same-cycle release and fire.
      $display("[TB] backpressure phase");
      @(negedge clk);
      bus.resp_ready = 1'b0;
      bus.req_addr   = 64'h8000_0010;
      bus.req_size   = 2'd3;
      bus.req_wen    = 1'b0;
      bus.req_id     = 4'd9;
      bus.req_valid  = 1'b1;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("bp_rvalid", 64'(bus.resp_valid), 64'd1);
      checkOutput("bp_rdata",  bus.resp_rdata, 64'h1122_3344_AB66_7788);
      checkOutput("bp_id",     64'(bus.resp_id), 64'd9);
      bus.req_addr  = 64'h8000_0014;
      bus.req_size  = 2'd2;
      bus.req_id    = 4'd10;
      bus.req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("stall_rvalid", 64'(bus.resp_valid), 64'd1);
         checkOutput("stall_rdata",  bus.resp_rdata, 64'h1122_3344_AB66_7788);
         checkOutput("stall_id",     64'(bus.resp_id), 64'd9);
         checkOutput("stall_ready",  64'(bus.req_ready), 64'd0);
      end
      bus.resp_ready = 1'b1;
      #1 checkOutput("release_ready", 64'(bus.req_ready), 64'd1);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      checkOutput("b2b_en",     64'(bus.dmem_en), 64'd1);
      checkOutput("b2b_addr",   bus.dmem_addr, 64'h8000_0010);
      checkOutput("b2b_rvalid", 64'(bus.resp_valid), 64'd0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("b2b_resp_valid", 64'(bus.resp_valid), 64'd1);
      checkOutput("b2b_rdata",      bus.resp_rdata, 64'h0000_0000_1122_3344);
      checkOutput("b2b_id",         64'(bus.resp_id), 64'd10);

      // Reset during the ACCESS cycle of a store.
      $display("[TB] reset-in-access phase");
      @(negedge clk);
      wcBefore      = writeCount;
      bus.req_addr  = 64'h8000_0020;
      bus.req_wdata = 64'hDEAD_BEEF_CAFE_F00D;
      bus.req_size  = 2'd3;
      bus.req_wen   = 1'b1;
      bus.req_id    = 4'd7;
      bus.req_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      reset         = 1'b1;
      @(negedge clk);
      checkOutput("rstacc_en",    64'(bus.dmem_en), 64'd0);
      checkOutput("rstacc_wen",   64'(bus.dmem_wen), 64'd0);
      checkOutput("rstacc_ready", 64'(bus.req_ready), 64'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checkOutput("rstacc_rvalid", 64'(bus.resp_valid), 64'd0);
      checkOutput("rstacc_ready_back", 64'(bus.req_ready), 64'd1);
      @(negedge clk);
      checkOutput("rstacc_no_resp", 64'(bus.resp_valid), 64'd0);
      checkOutput("rstacc_writes", 64'(writeCount - wcBefore), 64'd0);

      applyStimulus(64'h8000_0020, 64'd0, 2'd3, 1'b0, 4'd1);
      checkOutput("rstacc_old_data", respRdata, 64'hA5A5_5A5A_0000_0004);
      checkOutput("rstacc_ld_id",    64'(respId), 64'd1);

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
